stft_frame_buffer: RTL and testbench
====================================

# stft_frame_buffer

Circular sample store and frame launcher between the STFT sample-capture stage and the FFT core. It writes each captured sample into a FFT_SIZE-deep ring buffer on every `start_compute` pulse. Once the buffer is full, and then every HOP samples after that, it streams one full analysis frame (oldest sample first) to the FFT over a valid/ready handshake. Everything runs in the 27 MHz compute domain.

## Interface
Parameters:
- word_width, 16, stored/output sample width; 1 ≤ word_width ≤ 25
- FFT_SIZE, 512, frame length and ring depth; power of two, ≥ 4
- HOP, 128, new samples between frame launches; 1 ≤ HOP ≤ FFT_SIZE

Ports:
- clk  in  1  compute clock (27 MHz)
- RESET  in  1  synchronous, active-high reset
- start_compute  in  1  single-cycle pulse, new sample present on i_SAMPLE
- i_SAMPLE  in  25  captured sample, signed two's complement
- o_DATA  out  word_width  frame sample
- o_VALID  out  1  o_DATA valid
- i_READY  in  1  FFT accepts o_DATA this cycle
- o_FIRST  out  1  qualifies frame index 0
- o_LAST  out  1  qualifies frame index FFT_SIZE-1
- o_FRAME_DROP  out  1  one-cycle pulse, frame launch skipped
- o_PRIMED  out  1  ring holds FFT_SIZE valid samples

One clock; reset is synchronous and active-high.

## Operation
- Storage: mem[FFT_SIZE] of word_width bits. Stored value = i_SAMPLE[24:25-word_width] (MSB truncation, no rounding).
- Write, on start_compute:
  - mem[wr_ptr] ← sample; wr_ptr ← wr_ptr+1, wrapping to 0 after FFT_SIZE-1.
  - fill ← min(fill+1, FFT_SIZE).
  - Writes always proceed, including during STREAM.
- Launch request, evaluated on the write cycle:
  - Priming write (fill goes FFT_SIZE-1 → FFT_SIZE): request; hop ← 0.
  - Already primed: hop ← hop+1. When hop reaches HOP: request; hop ← 0.
- States:
  - IDLE: a request captures base = post-write wr_ptr (oldest sample), then → READ.
  - READ: issues the read of mem[base], then → STREAM.
  - STREAM: presents index k = 0..FFT_SIZE-1 at address (base+k) mod FFT_SIZE. When index FFT_SIZE-1 is accepted → IDLE.
- Busy rule: the block is busy in READ, or in STREAM unless index FFT_SIZE-1 is accepted that same cycle.
  - Request while busy: frame is dropped, o_FRAME_DROP pulses one cycle, hop still clears, the current frame continues untouched.
  - Request on the cycle of the final accept: launches normally and enters READ next cycle.
- Memory read is registered. A same-address read/write in one cycle returns the old data.
- Frame integrity holds only if stream index j is accepted before the j-th write after launch. With HOP ≤ FFT_SIZE and the 27 MHz/48 kHz ratio this is met whenever the FFT is not stalled for more than ~HOP sample periods. Integrity is not checked in hardware.

## Timing
- Reset values: o_DATA=0, o_VALID=0, o_FIRST=0, o_LAST=0, o_FRAME_DROP=0, o_PRIMED=0. Internally wr_ptr=0, fill=0, hop=0, state=IDLE. Memory contents are not cleared.
- Launching write at edge T:
  - READ during cycle T+1.
  - o_VALID=1 with index 0 and o_FIRST=1 from T+2.
- With i_READY held high: one index per cycle. Index FFT_SIZE-1 (o_LAST=1) at T+FFT_SIZE+1. o_VALID=0 at T+FFT_SIZE+2 unless a new launch is pending.
- Handshake:
  - A beat transfers when o_VALID && i_READY.
  - While o_VALID && !i_READY, o_DATA, o_FIRST and o_LAST hold stable.
  - o_VALID never drops mid-frame except on reset.
- o_PRIMED rises the cycle after the priming write and stays high until RESET.
- o_FRAME_DROP asserts the cycle after the rejected write.
- RESET mid-frame: o_VALID=0 from the next edge. The partial frame is abandoned. A full FFT_SIZE new samples are needed before the next launch.

## Test plan
- Priming: after reset, write samples k=0..511 as i_SAMPLE=k<<9, i_READY=1. No o_VALID through write 510. After write 511: o_DATA=0,1,…,511 on consecutive cycles from T+2, o_FIRST on 0, o_LAST on 511, o_PRIMED=1.
- Hop: continue with k=512..639. Exactly one new frame launches at write 639, carrying o_DATA=128..639 (mod 2^16), oldest first.
- Backpressure: random i_READY at 50%. Every frame contains all 512 values in order with no duplicates or gaps. o_DATA stays stable whenever o_VALID && !i_READY.
- Overrun: hold i_READY=0 mid-frame through 128 more writes. o_FRAME_DROP pulses once. After i_READY=1 the stalled frame completes, and only one frame is seen before the next hop.
- Boundary: time write 767 to land on the same cycle as the o_LAST accept. The new frame starts with no drop: READ next cycle, o_FIRST two cycles later.
- Reset mid-frame at index 200: o_VALID=0 next cycle and o_PRIMED=0. No frame appears until 512 fresh writes, and that frame holds only the post-reset samples.

Source files
------------

// File: rtl/stft_frame_buffer.sv
// -----------------------------------------------------------------------------
// stft_frame_buffer
//
// Circular sample store and frame launcher that sits between the STFT sample
// capture stage and the FFT core. Each start_compute pulse writes one captured
// sample into an FFT_SIZE-deep ring. The first full frame launches once the
// ring is full. After that, one frame launches every HOP samples. Each frame
// is FFT_SIZE samples, oldest first, sent to the FFT over a valid/ready
// handshake. Everything runs on the single compute clock.
//
// Parameters
//   word_width : stored/output sample width (1..25), MSB-truncated from input
//   FFT_SIZE   : frame length and ring depth (power of two, >= 4)
//   HOP        : new samples between frame launches (1..FFT_SIZE)
//
// Ports
//   clk           : compute clock
//   RESET         : synchronous, active-high reset
//   start_compute : one-cycle pulse, new sample present on i_SAMPLE
//   i_SAMPLE      : captured sample, signed two's complement, 25 bits
//   o_DATA        : frame sample
//   o_VALID       : o_DATA valid
//   i_READY       : FFT accepts o_DATA this cycle
//   o_FIRST       : marks frame index 0
//   o_LAST        : marks frame index FFT_SIZE-1
//   o_FRAME_DROP  : one-cycle pulse, a launch request was skipped (busy)
//   o_PRIMED      : ring holds FFT_SIZE valid samples since reset
// -----------------------------------------------------------------------------
module stft_frame_buffer #(
  parameter int word_width = 16,
  parameter int FFT_SIZE   = 512,
  parameter int HOP        = 128
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start_compute,
  input  logic [24:0]           i_SAMPLE,
  output logic [word_width-1:0] o_DATA,
  output logic                  o_VALID,
  input  logic                  i_READY,
  output logic                  o_FIRST,
  output logic                  o_LAST,
  output logic                  o_FRAME_DROP,
  output logic                  o_PRIMED
);

  localparam int unsigned AW = $clog2(FFT_SIZE);
  localparam int unsigned HW = (HOP > 1) ? $clog2(HOP) : 1;

  localparam logic [AW:0]   FILL_FULL    = (AW+1)'(FFT_SIZE);
  localparam logic [AW:0]   FILL_PRIME   = (AW+1)'(FFT_SIZE - 1);
  localparam logic [HW-1:0] HOP_LAST     = HW'(HOP - 1);
  localparam logic [AW-1:0] IDX_PRE_LAST = AW'(FFT_SIZE - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_STREAM
  } state_t;

  // Sample ring; contents deliberately survive reset.
  logic [word_width-1:0] mem [FFT_SIZE];

  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill;
  logic [HW-1:0] hop;

  state_t        state;
  logic [AW-1:0] base;      // ring address of frame index 0
  logic [AW-1:0] idx;       // index currently presented on o_DATA
  logic [AW-1:0] rd_addr;

  logic priming_wr;
  logic hop_wr;
  logic launch_req;
  logic accept;
  logic last_accept;
  logic busy;

  // Only the upper word_width bits of the sample are kept.
  logic unused_sample;
  assign unused_sample = ^i_SAMPLE;

  always_comb begin
    priming_wr  = start_compute && (fill == FILL_PRIME);
    hop_wr      = start_compute && (fill == FILL_FULL) && (hop == HOP_LAST);
    launch_req  = priming_wr || hop_wr;
    accept      = o_VALID && i_READY;
    last_accept = accept && o_LAST;
    // A request that lands on the final accept still launches normally.
    busy        = (state == S_READ) || ((state == S_STREAM) && !last_accept);
    // In READ fetch index 0. In STREAM prefetch the index after the one
    // currently shown.
    rd_addr     = (state == S_READ) ? base : (base + idx + AW'(1));
  end

  // Ring write port. Writes never stall, including while a frame streams.
  always_ff @(posedge clk) begin
    if (start_compute) begin
      mem[wr_ptr] <= i_SAMPLE[24 -: word_width];
    end
  end

  // Write bookkeeping: pointer, fill level, hop counter, status pulses.
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr       <= '0;
      fill         <= '0;
      hop          <= '0;
      o_PRIMED     <= 1'b0;
      o_FRAME_DROP <= 1'b0;
    end else begin
      o_FRAME_DROP <= launch_req && busy;
      if (start_compute) begin
        // FFT_SIZE is a power of two, so natural overflow gives the wrap.
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != FILL_FULL) begin
          fill <= fill + (AW+1)'(1);
        end
        // The hop counter clears on every request, including dropped ones.
        if (launch_req) begin
          hop <= '0;
        end else if (fill == FILL_FULL) begin
          hop <= hop + HW'(1);
        end
      end
      if (priming_wr) begin
        o_PRIMED <= 1'b1;
      end
    end
  end

  // Frame launcher and stream. o_DATA is the registered read port output.
  // It only advances on an accepted beat, so it stays stable under
  // backpressure even while new samples overwrite the ring.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= S_IDLE;
      base    <= '0;
      idx     <= '0;
      o_DATA  <= '0;
      o_VALID <= 1'b0;
      o_FIRST <= 1'b0;
      o_LAST  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch_req) begin
            // The post-write pointer addresses the oldest sample.
            base  <= wr_ptr + AW'(1);
            state <= S_READ;
          end
        end

        S_READ: begin
          o_DATA  <= mem[rd_addr];
          o_VALID <= 1'b1;
          o_FIRST <= 1'b1;
          o_LAST  <= 1'b0;
          idx     <= '0;
          state   <= S_STREAM;
        end

        S_STREAM: begin
          if (accept) begin
            if (o_LAST) begin
              o_VALID <= 1'b0;
              o_FIRST <= 1'b0;
              o_LAST  <= 1'b0;
              if (launch_req) begin
                base  <= wr_ptr + AW'(1);
                state <= S_READ;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              o_DATA  <= mem[rd_addr];
              idx     <= idx + AW'(1);
              o_FIRST <= 1'b0;
              o_LAST  <= (idx == IDX_PRE_LAST);
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stft_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_stft_frame_buffer
//
// Scoreboard bench for stft_frame_buffer (word_width=16, FFT_SIZE=512,
// HOP=128). Write k carries i_SAMPLE = v<<9, so the stored 16-bit word is
// v mod 2^16. A stimulus process issues directed writes. For each launch it
// pushes the expected frame, which is the last 512 written values, oldest
// first. A negedge monitor pops one entry and compares it on every accepted
// beat. It also checks that outputs hold stable under backpressure.
// -----------------------------------------------------------------------------
module tb_stft_frame_buffer;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start_compute;
  logic [24:0] i_SAMPLE;
  logic [15:0] o_DATA;
  logic        o_VALID;
  logic        i_READY;
  logic        o_FIRST;
  logic        o_LAST;
  logic        o_FRAME_DROP;
  logic        o_PRIMED;

  stft_frame_buffer #(
    .word_width(16),
    .FFT_SIZE  (512),
    .HOP       (128)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .start_compute(start_compute),
    .i_SAMPLE     (i_SAMPLE),
    .o_DATA       (o_DATA),
    .o_VALID      (o_VALID),
    .i_READY      (i_READY),
    .o_FIRST      (o_FIRST),
    .o_LAST       (o_LAST),
    .o_FRAME_DROP (o_FRAME_DROP),
    .o_PRIMED     (o_PRIMED)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] hist [0:4095];
  int          nwr        = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          drops_seen = 0;
  int          exp_drops  = 0;
  int unsigned rdy_mode   = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One write. The caller states whether it launches a frame, drops one,
  // and what o_PRIMED must read afterwards.
  task automatic do_write(input int unsigned val, input bit exp_launch,
                          input bit exp_drop, input bit exp_primed);
    beat_t b;
    i_SAMPLE      = 25'(val << 9);
    hist[nwr]     = val[15:0];
    nwr++;
    if (exp_launch) begin
      for (int j = 0; j < 512; j++) begin
        b.data  = hist[nwr - 512 + j];
        b.first = (j == 0);
        b.last  = (j == 511);
        exp_q.push_back(b);
      end
    end
    if (exp_drop) exp_drops++;
    start_compute = 1'b1;
    @(posedge clk);
    #1;
    start_compute = 1'b0;
    check("frame_drop_after_write", o_FRAME_DROP, exp_drop);
    check("primed_after_write", o_PRIMED, exp_primed);
    if (exp_launch) begin
      check("launch_read_cycle_valid_low", o_VALID, 1'b0);
      @(posedge clk);
      #1;
      check("launch_first_beat", {o_VALID, o_FIRST, o_DATA},
            {1'b1, 1'b1, hist[nwr - 512]});
    end
  endtask

  // Ready driver, 2 ns after the edge so mode changes made at +1 take effect
  // in the same cycle.
  initial begin
    i_READY = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       i_READY = 1'b0;
        1:       i_READY = 1'b1;
        default: i_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each accepted beat against the scoreboard.
  logic        prev_hold  = 1'b0;
  logic        prev_first = 1'b0;
  logic        prev_last  = 1'b0;
  logic [15:0] prev_data  = '0;

  always @(negedge clk) begin
    beat_t b;
    if (o_FRAME_DROP) drops_seen++;
    if (!RESET) begin
      if (prev_hold) begin
        check("hold_stable", {o_VALID, o_FIRST, o_LAST, o_DATA},
              {1'b1, prev_first, prev_last, prev_data});
      end
      if (o_VALID && i_READY) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat", {o_DATA, o_FIRST, o_LAST}, {b.data, b.first, b.last});
        end
      end
    end
    prev_hold  = !RESET && o_VALID && !i_READY;
    prev_first = o_FIRST;
    prev_last  = o_LAST;
    prev_data  = o_DATA;
  end

  initial begin
    bit found;
    RESET         = 1'b1;
    start_compute = 1'b0;
    i_SAMPLE      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {o_DATA, o_VALID, o_FIRST, o_LAST, o_FRAME_DROP, o_PRIMED}, '0);
    RESET = 1'b0;
    idle(2);

    // Priming: no frame until write 511, then 0..511.
    for (int k = 0; k < 512; k++) begin
      do_write(k, k == 511, 1'b0, k == 511);
      idle(5);
    end

    // Hop: one launch at write 639 carrying 128..639.
    for (int k = 512; k < 640; k++) begin
      do_write(k, k == 639, 1'b0, 1'b1);
      idle(5);
    end

    // Boundary: write 767 lands on the o_LAST accept of the 639 frame.
    for (int k = 640; k < 767; k++) begin
      do_write(k, 1'b0, 1'b0, 1'b1);
      if (k != 766) idle(3);
    end
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (o_VALID && o_LAST) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("boundary_last_reached", found, 1'b1);
    do_write(767, 1'b1, 1'b0, 1'b1);

    // Backpressure: random ready across the 767 and 895 frames.
    rdy_mode = 2;
    idle(11);
    for (int k = 768; k < 1023; k++) begin
      do_write(k, k == 895, 1'b0, 1'b1);
      idle(11);
    end
    rdy_mode = 1;
    do_write(1023, 1'b1, 1'b0, 1'b1);

    // Overrun: stall near index 300 through 128 writes; write 1151 drops.
    idle(300);
    rdy_mode = 0;
    for (int k = 1024; k < 1152; k++) begin
      do_write(k, 1'b0, k == 1151, 1'b1);
      idle(3);
    end
    rdy_mode = 1;
    for (int k = 1152; k < 1280; k++) begin
      do_write(k, k == 1279, 1'b0, 1'b1);
      if (k != 1279) idle(11);
    end

    // Reset while frame index 200 is presented.
    idle(200);
    check("pre_reset_index200", {o_VALID, o_DATA}, {1'b1, hist[1279 - 511 + 200]});
    RESET = 1'b1;
    @(posedge clk);
    #1;
    check("mid_frame_reset", {o_VALID, o_FIRST, o_LAST, o_PRIMED, o_DATA},
          '0);
    exp_q.delete();
    RESET = 1'b0;
    idle(3);

    // Fresh fill: the only frame comes at the 512th write, all new values.
    for (int k = 0; k < 512; k++) begin
      do_write(3000 + k, k == 511, 1'b0, k == 511);
      idle(5);
    end

    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);
    check("drop_pulse_count", drops_seen, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
